// File: rtl/dco_cal_pkg.sv
// Shared types and helpers for the DCO coarse-band calibration slice.
// State/phase encodings, window/trial length helpers, signed error type.
package dco_cal_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SNAP,
    S_MEAS,
    S_DECIDE,
    S_DONE
  } cal_state_e;

  typedef enum logic [1:0] {
    PH_COARSE,
    PH_FINE,
    PH_VERIFY
  } cal_phase_e;

  localparam int CNT_W_DFLT = 16;

  typedef logic signed [CNT_W_DFLT:0] cal_err_t;

  function automatic int win_len(input int log2);
    return 1 << log2;
  endfunction

  function automatic int trial_len(input int settle, input int log2);
    return settle + win_len(log2) + 2;
  endfunction

endpackage

// File: rtl/dco_cal_sar.sv
// Generic W-bit successive-approximation register, offset-binary inside,
// two's complement code out (MSB inverted).
module dco_cal_sar
  import dco_cal_pkg::*;
#(
  parameter int W = 6
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                init,
  input  logic                step,
  input  logic                err_pos,
  output logic signed [W-1:0] code,
  output logic                last
);

  localparam int PW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0]  sar;
  logic [PW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (!resetn || init) begin
      sar <= MSB;
      ptr <= PW'(W - 1);
    end else if (step) begin
      // A tie (err == 0) keeps the bit, biasing toward the higher code.
      if (err_pos) sar[ptr] <= 1'b0;
      if (ptr != '0) begin
        sar[ptr - PW'(1)] <= 1'b1;
        ptr <= ptr - PW'(1);
      end
    end
  end

  assign code = sar ^ MSB;
  assign last = (ptr == '0);

endmodule

// File: rtl/dco_coarse_cal.sv
// DCO coarse-band SAR calibration on refclk; counts DCO edges per window.
// Define FINE_CAL_EN to follow the coarse search with a fine-code search.
module dco_coarse_cal
  import dco_cal_pkg::*;
#(
  parameter int CW       = 6,
  parameter int FW       = 8,
  parameter int CNT_W    = 16,
  parameter int WIN_LOG2 = 4,
  parameter int SETTLE   = 8,
  parameter int CAL_TOL  = 8
) (
  input  logic                  refclk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [11:0]           fcw_int,
  input  logic [CNT_W-1:0]      dco_cnt,
  output logic signed [CW-1:0]  dctrl_coarse,
  output logic signed [FW-1:0]  dctrl_fine,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic signed [CNT_W:0] cal_err
);

  localparam int WIN  = win_len(WIN_LOG2);
  localparam int TMAX = (SETTLE > WIN) ? SETTLE : WIN;
  localparam int TW   = $clog2(TMAX + 1);

  cal_state_e state;
  cal_phase_e phase;

  logic [TW-1:0]         tcnt;
  logic [CNT_W:0]        target;
  logic [CNT_W:0]        tgt_req;
  logic [CNT_W-1:0]      c0;
  logic [CNT_W-1:0]      delta;
  logic signed [CNT_W:0] err;
  logic [CNT_W:0]        err_mag;
  logic                  err_pos;
  logic                  idle;
  logic                  accept;
  logic                  c_step;
  logic                  c_last;
  logic                  f_last;

  assign tgt_req = (CNT_W+1)'(fcw_int) << WIN_LOG2;
  assign idle    = (state == S_IDLE) || (state == S_DONE);
  assign accept  = idle && start && !tgt_req[CNT_W];
  assign err     = $signed({1'b0, delta}) - $signed(target);
  assign err_mag = err[CNT_W] ? $unsigned(-err) : $unsigned(err);
  assign err_pos = !err[CNT_W] && (err != '0);
  assign c_step  = (state == S_DECIDE) && (phase == PH_COARSE);

  dco_cal_sar #(.W(CW)) u_coarse (
    .clk     (refclk),
    .resetn  (resetn),
    .init    (accept),
    .step    (c_step),
    .err_pos (err_pos),
    .code    (dctrl_coarse),
    .last    (c_last)
  );

`ifdef FINE_CAL_EN
  localparam cal_phase_e PH_POST = PH_FINE;
  logic f_step;
  assign f_step = (state == S_DECIDE) && (phase == PH_FINE);

  dco_cal_sar #(.W(FW)) u_fine (
    .clk     (refclk),
    .resetn  (resetn),
    .init    (accept),
    .step    (f_step),
    .err_pos (err_pos),
    .code    (dctrl_fine),
    .last    (f_last)
  );
`else
  localparam cal_phase_e PH_POST = PH_VERIFY;
  assign f_last     = 1'b1;
  assign dctrl_fine = '0;
`endif

  always_ff @(posedge refclk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      phase   <= PH_COARSE;
      tcnt    <= '0;
      target  <= '0;
      c0      <= '0;
      delta   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
      cal_err <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (tgt_req[CNT_W]) begin
              state   <= S_DONE;
              done    <= 1'b1;
              fail    <= 1'b1;
              cal_err <= '0;
            end else begin
              state  <= S_SETTLE;
              phase  <= PH_COARSE;
              tcnt   <= '0;
              target <= tgt_req;
              busy   <= 1'b1;
              done   <= 1'b0;
              fail   <= 1'b0;
            end
          end
        end
        S_SETTLE: begin
          if (tcnt == TW'(SETTLE - 1)) begin
            state <= S_SNAP;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_SNAP: begin
          c0    <= dco_cnt;
          state <= S_MEAS;
        end
        S_MEAS: begin
          // End sample taken here so the window spans exactly WIN periods.
          if (tcnt == TW'(WIN - 1)) begin
            delta <= dco_cnt - c0;
            state <= S_DECIDE;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_DECIDE: begin
          state <= S_SETTLE;
          unique case (phase)
            PH_COARSE: if (c_last) phase <= PH_POST;
            PH_FINE:   if (f_last) phase <= PH_VERIFY;
            default: begin
              state   <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              cal_err <= err;
              fail    <= err_mag > (CNT_W+1)'(CAL_TOL);
            end
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dco_coarse_cal.sv
// Directed bench for dco_coarse_cal against a behavioural DCO model
// (3 GHz + 50 MHz/code, clipped 2..6 GHz) on a 100 MHz refclk.
`timescale 1ns/1ps
module tb_dco_coarse_cal;
  import dco_cal_pkg::*;

  logic              refclk = 1'b0;
  logic              resetn = 1'b0;
  logic              start  = 1'b0;
  logic              start2 = 1'b0;
  logic [11:0]       fcw    = '0;
  logic [15:0]       dco_cnt = '0;
  logic signed [5:0] coarse, coarse2;
  logic signed [7:0] fine, fine2;
  logic              busy, done, fail;
  logic              busy2, done2, fail2;
  cal_err_t          cal_err, cal_err2;

  longint acc = 0;
  longint cnt_ofs = 0;
  int     npass = 0;
  int     ntotal = 0;
  int     lat;
  logic   b1;

  always #5 refclk = ~refclk;

  dco_coarse_cal dut (
    .refclk       (refclk),
    .resetn       (resetn),
    .start        (start),
    .fcw_int      (fcw),
    .dco_cnt      (dco_cnt),
    .dctrl_coarse (coarse),
    .dctrl_fine   (fine),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .cal_err      (cal_err)
  );

  dco_coarse_cal #(.WIN_LOG2(5)) dut2 (
    .refclk       (refclk),
    .resetn       (resetn),
    .start        (start2),
    .fcw_int      (fcw),
    .dco_cnt      (dco_cnt),
    .dctrl_coarse (coarse2),
    .dctrl_fine   (fine2),
    .busy         (busy2),
    .done         (done2),
    .fail         (fail2),
    .cal_err      (cal_err2)
  );

  function automatic longint f_mhz(input logic signed [5:0] c);
    longint f;
    f = 3000 + 50 * longint'(c);
    if (f < 2000) f = 2000;
    if (f > 6000) f = 6000;
    return f;
  endfunction

  // Edge accumulator in MHz*cycles; count = acc/100 per 10 ns period.
  always @(negedge refclk) begin
    acc = acc + f_mhz(coarse);
    dco_cnt = 16'(acc / 100 + cnt_ofs);
  end

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic run_cal(input logic [11:0] f, input int poke,
                         output int n, output logic b);
    fcw = f;
    @(negedge refclk);
    start = 1'b1;
    @(posedge refclk);
    #1;
    start = 1'b0;
    n = 1;
    b = busy;
    while (!done && n < 400) begin
      if (n == poke) start = 1'b1;
      @(posedge refclk);
      #1;
      start = 1'b0;
      n++;
    end
    if (!done) n = -1;
  endtask

  initial begin
    repeat (3) @(posedge refclk);
    #1;
    chk("rst_coarse", coarse, 0);
    chk("rst_fine", fine, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_err", cal_err, 0);
    resetn = 1'b1;

    // 3.5 GHz target: code +10 lands exactly (560 counts)
    run_cal(12'd35, -1, lat, b1);
    chk("s1_busy", b1, 1);
    chk("s1_latency", lat, 183);
    chk("s1_coarse", coarse, 10);
    chk("s1_err", cal_err, 0);
    chk("s1_fail", fail, 0);
    chk("s1_busy_end", busy, 0);
    chk("s1_fine", fine, 0);

    // 7 GHz: saturates at +31 (4.55 GHz -> 728 counts vs 1120)
    run_cal(12'd70, -1, lat, b1);
    chk("s2_coarse", coarse, 31);
    chk("s2_err", cal_err, -392);
    chk("s2_fail", fail, 1);

    // 1.5 GHz: bottoms out at -32, DCO clipped at 2 GHz (320 vs 240)
    run_cal(12'd15, -1, lat, b1);
    chk("s3_coarse", coarse, -32);
    chk("s3_err", cal_err, 80);
    chk("s3_fail", fail, 1);

    // Reset in the third trial's window; code there is +8
    fcw = 12'd35;
    @(negedge refclk);
    start = 1'b1;
    @(posedge refclk);
    #1;
    start = 1'b0;
    repeat (65) @(posedge refclk);
    #1;
    chk("s6_mid_coarse", coarse, 8);
    chk("s6_mid_busy", busy, 1);
    resetn = 1'b0;
    @(posedge refclk);
    #1;
    chk("s6_rst_coarse", coarse, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_done", done, 0);
    chk("s6_rst_err", cal_err, 0);
    resetn = 1'b1;
    run_cal(12'd35, 50, lat, b1);
    chk("s6_latency", lat, 183);
    chk("s6_coarse", coarse, 10);
    chk("s6_err", cal_err, 0);
    chk("s6_fail", fail, 0);

    // Largest in-range target: 65520 counts, runs full length
    run_cal(12'd4095, -1, lat, b1);
    chk("s4_latency", lat, 183);
    chk("s4_coarse", coarse, 31);
    chk("s4_err", cal_err, -64792);
    chk("s4_fail", fail, 1);

    // Same fcw with a 32-cycle window overflows 16 bits
    @(negedge refclk);
    start2 = 1'b1;
    @(posedge refclk);
    #1;
    start2 = 1'b0;
    chk("s4b_done", done2, 1);
    chk("s4b_fail", fail2, 1);
    chk("s4b_err", cal_err2, 0);
    chk("s4b_coarse", coarse2, 0);
    chk("s4b_busy", busy2, 0);
    chk("s4b_fine", fine2, 0);

    // Counter near full scale so it wraps in the first window
    cnt_ofs = 65200 - acc / 100;
    run_cal(12'd35, -1, lat, b1);
    chk("s5_latency", lat, 183);
    chk("s5_coarse", coarse, 10);
    chk("s5_err", cal_err, 0);
    chk("s5_fail", fail, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
